// File: rtl/uplink_pkg.sv
// uplink_router shared types, select encoding and helpers.
// Optional gain stage is built with UPLINK_ROUTER_GAIN_EN.
package uplink_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int N_LNK_DEFAULT = 4;
  localparam int N_SV_DEFAULT = 4;

  localparam int LNK_BASE = 0;
  localparam int SV_BASE = LNK_BASE + N_LNK_DEFAULT;
  localparam int MUTE = SV_BASE + N_SV_DEFAULT;

  typedef enum logic {
    CFG_RUN,
    CFG_PEND
  } cfg_state_e;

  function automatic int reset_src(input int k, input int n_lnk);
    return LNK_BASE + (k % n_lnk);
  endfunction

  function automatic logic signed [31:0] sat_clip(
    input logic signed [31:0] v,
    input int dw
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/uplink_srv_sel.sv
// One DL service output: source mux, optional gain/saturate, output register.
// Gain stage present only with UPLINK_ROUTER_GAIN_EN.
module uplink_srv_sel
  import uplink_pkg::*;
#(
  parameter int N_LNK = 4,
  parameter int N_SV  = 4,
  parameter int DW    = DW_DEFAULT,
  parameter int SEL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_LNK*DW-1:0]   lnk_i,
  input  logic [N_LNK*DW-1:0]   lnk_q,
  input  logic                  lnk_valid,
  input  logic [N_SV*DW-1:0]    sv_i,
  input  logic [N_SV*DW-1:0]    sv_q,
  input  logic                  sv_valid,
  input  logic [SEL_W-1:0]      sel,
`ifdef UPLINK_ROUTER_GAIN_EN
  input  logic [2:0]            gain,
  output logic                  sat_flag,
`endif
  output logic [DW-1:0]         o_i,
  output logic [DW-1:0]         o_q,
  output logic                  o_valid
);

  logic [DW-1:0] src_i, src_q, res_i, res_q;
  logic          src_v, mute;
  logic [DW-1:0] o_i_d, o_i_q, o_q_d, o_q_q;
  logic          o_valid_d, o_valid_q;

  always_comb begin
    src_i = '0;
    src_q = '0;
    src_v = 1'b0;
    mute  = (int'(sel) >= N_LNK + N_SV);
    for (int k = 0; k < N_LNK; k++) begin
      if (int'(sel) == LNK_BASE + k) begin
        src_i = lnk_i[k*DW +: DW];
        src_q = lnk_q[k*DW +: DW];
        src_v = lnk_valid;
      end
    end
    for (int k = 0; k < N_SV; k++) begin
      if (int'(sel) == N_LNK + k) begin
        src_i = sv_i[k*DW +: DW];
        src_q = sv_q[k*DW +: DW];
        src_v = sv_valid;
      end
    end
  end

`ifdef UPLINK_ROUTER_GAIN_EN
  localparam logic signed [31:0] HI = (32'sd1 <<< (DW - 1)) - 32'sd1;
  localparam logic signed [31:0] LO = -HI - 32'sd1;

  logic signed [31:0] cl_i, cl_q;
  logic sat_now, sat_d, sat_q;

  always_comb begin
    cl_i = sat_clip(32'($signed(src_i)) <<< gain, DW);
    cl_q = sat_clip(32'($signed(src_q)) <<< gain, DW);
    res_i = cl_i[DW-1:0];
    res_q = cl_q[DW-1:0];
    // flag any sample pinned at a rail, clipped or landing exactly there
    sat_now = src_v & ((cl_i == HI) | (cl_i == LO) |
                       (cl_q == HI) | (cl_q == LO));
    sat_d = sat_q | sat_now;
  end

  always_ff @(posedge clk) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= sat_d;
  end

  assign sat_flag = sat_q;
`else
  always_comb begin
    res_i = src_i;
    res_q = src_q;
  end
`endif

  always_comb begin
    o_i_d = o_i_q;
    o_q_d = o_q_q;
    o_valid_d = src_v;
    if (mute) begin
      o_i_d = '0;
      o_q_d = '0;
    end else if (src_v) begin
      o_i_d = res_i;
      o_q_d = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_i_q <= '0;
      o_q_q <= '0;
      o_valid_q <= 1'b0;
    end else begin
      o_i_q <= o_i_d;
      o_q_q <= o_q_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_i = o_i_q;
  assign o_q = o_q_q;
  assign o_valid = o_valid_q;

endmodule

// File: rtl/uplink_router.sv
// Uplink/service RX router with frame-aligned map switching.
// Optional per-output gain with UPLINK_ROUTER_GAIN_EN.
module uplink_router
  import uplink_pkg::*;
#(
  parameter int N_LNK     = 4,
  parameter int N_SV      = 4,
  parameter int N_SRV     = 4,
  parameter int DW        = DW_DEFAULT,
  parameter int FRAME_LEN = 1024,
  parameter int SEL_W     = $clog2(N_LNK + N_SV + 1),
  parameter int TP_W      = (N_LNK > 1) ? $clog2(N_LNK) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_LNK*DW-1:0]     lnk_rx_i,
  input  logic [N_LNK*DW-1:0]     lnk_rx_q,
  input  logic                    lnk_rx_valid,
  input  logic [N_SV*DW-1:0]      sv_rx_i,
  input  logic [N_SV*DW-1:0]      sv_rx_q,
  input  logic                    sv_rx_valid,
  input  logic [N_SRV*SEL_W-1:0]  cfg_sel,
  input  logic [TP_W-1:0]         cfg_tp_sel,
  input  logic                    cfg_load,
`ifdef UPLINK_ROUTER_GAIN_EN
  input  logic [N_SRV*3-1:0]      cfg_gain,
  output logic [N_SRV-1:0]        sat_flag,
`endif
  output logic                    cfg_pending,
  output logic                    frame_start,
  output logic [DW-1:0]           lnk_tp_i,
  output logic [DW-1:0]           lnk_tp_q,
  output logic                    lnk_tp_valid,
  output logic [N_SV*DW-1:0]      sv_tp_i,
  output logic [N_SV*DW-1:0]      sv_tp_q,
  output logic                    sv_tp_valid,
  output logic [N_SRV*DW-1:0]     dl_srv_i,
  output logic [N_SRV*DW-1:0]     dl_srv_q,
  output logic [N_SRV-1:0]        dl_srv_valid
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             boundary;

  always_comb begin
    cnt_d = cnt_q;
    if (lnk_rx_valid) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    boundary = lnk_rx_valid & (cnt_q == LAST);
  end

  cfg_state_e             state_q;
  logic [N_SRV*SEL_W-1:0] act_sel_q, shd_sel_q;
  logic [TP_W-1:0]        act_tp_q, shd_tp_q;
`ifdef UPLINK_ROUTER_GAIN_EN
  logic [N_SRV*3-1:0]     act_gain_q, shd_gain_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CFG_RUN;
      shd_sel_q <= '0;
      shd_tp_q <= '0;
      act_tp_q <= '0;
      for (int k = 0; k < N_SRV; k++)
        act_sel_q[k*SEL_W +: SEL_W] <= SEL_W'(reset_src(k, N_LNK));
`ifdef UPLINK_ROUTER_GAIN_EN
      shd_gain_q <= '0;
      act_gain_q <= '0;
`endif
    end else begin
      unique case (state_q)
        CFG_RUN: if (cfg_load) state_q <= CFG_PEND;
        CFG_PEND: begin
          if (boundary) begin
            act_sel_q <= shd_sel_q;
            act_tp_q <= shd_tp_q;
`ifdef UPLINK_ROUTER_GAIN_EN
            act_gain_q <= shd_gain_q;
`endif
            if (!cfg_load) state_q <= CFG_RUN;
          end
        end
      endcase
      // a load on the boundary cycle lands after the old shadow is applied
      if (cfg_load) begin
        shd_sel_q <= cfg_sel;
        shd_tp_q <= cfg_tp_sel;
`ifdef UPLINK_ROUTER_GAIN_EN
        shd_gain_q <= cfg_gain;
`endif
      end
    end
  end

  logic [DW-1:0]      tp_i_d, tp_i_q, tp_q_d, tp_q_q;
  logic [N_SV*DW-1:0] svt_i_d, svt_i_q, svt_q_d, svt_q_q;
  logic               fs_q, tpv_q, svv_q;

  always_comb begin
    tp_i_d = tp_i_q;
    tp_q_d = tp_q_q;
    svt_i_d = svt_i_q;
    svt_q_d = svt_q_q;
    if (lnk_rx_valid) begin
      tp_i_d = lnk_rx_i[int'(act_tp_q)*DW +: DW];
      tp_q_d = lnk_rx_q[int'(act_tp_q)*DW +: DW];
    end
    if (sv_rx_valid) begin
      svt_i_d = sv_rx_i;
      svt_q_d = sv_rx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tp_i_q <= '0;
      tp_q_q <= '0;
      svt_i_q <= '0;
      svt_q_q <= '0;
      fs_q <= 1'b0;
      tpv_q <= 1'b0;
      svv_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tp_i_q <= tp_i_d;
      tp_q_q <= tp_q_d;
      svt_i_q <= svt_i_d;
      svt_q_q <= svt_q_d;
      fs_q <= lnk_rx_valid & (cnt_q == '0);
      tpv_q <= lnk_rx_valid;
      svv_q <= sv_rx_valid;
    end
  end

  assign cfg_pending = (state_q == CFG_PEND);
  assign frame_start = fs_q;
  assign lnk_tp_i = tp_i_q;
  assign lnk_tp_q = tp_q_q;
  assign lnk_tp_valid = tpv_q;
  assign sv_tp_i = svt_i_q;
  assign sv_tp_q = svt_q_q;
  assign sv_tp_valid = svv_q;

  for (genvar k = 0; k < N_SRV; k++) begin : g_srv
    uplink_srv_sel #(
      .N_LNK(N_LNK), .N_SV(N_SV), .DW(DW), .SEL_W(SEL_W)
    ) u_sel (
      .clk       (clk),
      .rst       (rst),
      .lnk_i     (lnk_rx_i),
      .lnk_q     (lnk_rx_q),
      .lnk_valid (lnk_rx_valid),
      .sv_i      (sv_rx_i),
      .sv_q      (sv_rx_q),
      .sv_valid  (sv_rx_valid),
      .sel       (act_sel_q[k*SEL_W +: SEL_W]),
`ifdef UPLINK_ROUTER_GAIN_EN
      .gain      (act_gain_q[k*3 +: 3]),
      .sat_flag  (sat_flag[k]),
`endif
      .o_i       (dl_srv_i[k*DW +: DW]),
      .o_q       (dl_srv_q[k*DW +: DW]),
      .o_valid   (dl_srv_valid[k])
    );
  end

endmodule
